// File: rtl/food_placement_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : food_placement_ctrl
// Purpose  : Chooses a free playfield cell for the snake food. Free-running
//            LFSR coordinates are filtered to the playfield, snapped to the
//            cell grid and checked against the snake occupancy map. After
//            MAX_TRIES random collisions it falls back to a raster scan of
//            the whole grid, and reports either the committed food cell or a
//            full board.
// Ports    : clk1        - block clock
//            rst         - asynchronous active-high reset
//            req         - place-food request, sampled only while idle
//            rnd_x/rnd_y - LFSR coordinates, new value every cycle
//            occ_x/occ_y - registered occupancy query (cell aligned)
//            occ_hit     - same-cycle occupancy answer for occ_x/occ_y
//            xFood/yFood - committed food position (cell aligned)
//            food_valid  - xFood/yFood hold a placed food
//            busy        - placement in progress
//            done        - one-cycle pulse when food is committed
//            board_full  - sticky, no free cell found; cleared by next req
// Revision : 1.0 - initial release
// ============================================================================
module food_placement_ctrl #(
  parameter int X_MIN     = 144,
  parameter int X_MAX     = 783,
  parameter int Y_MIN     = 35,
  parameter int Y_MAX     = 514,
  parameter int GRID_LOG2 = 4,
  parameter int MAX_TRIES = 32
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       req,
  input  logic [9:0] rnd_x,
  input  logic [9:0] rnd_y,
  output logic [9:0] occ_x,
  output logic [9:0] occ_y,
  input  logic       occ_hit,
  output logic [9:0] xFood,
  output logic [9:0] yFood,
  output logic       food_valid,
  output logic       busy,
  output logic       done,
  output logic       board_full
);

  localparam int G_SIZE = 1 << GRID_LOG2;
  localparam int NX     = (X_MAX - X_MIN + 1) >> GRID_LOG2;
  localparam int NY     = (Y_MAX - Y_MIN + 1) >> GRID_LOG2;
  localparam int NCELLS = NX * NY;
  localparam int SCAN_W = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [9:0]        c_x_min      = 10'(X_MIN);
  localparam logic [9:0]        c_y_min      = 10'(Y_MIN);
  // Last cell origin: a candidate must leave a full cell inside the field.
  localparam logic [9:0]        c_x_last     = 10'(X_MAX - G_SIZE + 1);
  localparam logic [9:0]        c_y_last     = 10'(Y_MAX - G_SIZE + 1);
  localparam logic [9:0]        c_g          = 10'(G_SIZE);
  localparam logic [9:0]        c_align_mask = ~10'(G_SIZE - 1);
  localparam logic [TRY_W-1:0]  c_try_last   = TRY_W'(MAX_TRIES - 1);
  localparam logic [SCAN_W-1:0] c_scan_last  = SCAN_W'(NCELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_CHECK  = 3'd2,
    S_SCAN   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [9:0]          r_occ_x;
  logic [9:0]          r_occ_y;
  logic [9:0]          r_food_x;
  logic [9:0]          r_food_y;
  logic                r_food_valid;
  logic                r_done;
  logic                r_board_full;
  logic [TRY_W-1:0]    r_tries;
  logic [SCAN_W-1:0]   r_scan_cnt;

  logic                w_in_range;
  logic [9:0]          w_cand_x;
  logic [9:0]          w_cand_y;
  logic                w_col_last;
  logic                w_row_last;
  logic [9:0]          w_next_x;
  logic [9:0]          w_next_y;

  logic                w_start;
  logic                w_load;
  logic                w_try_inc;
  logic                w_scan_clr;
  logic                w_scan_step;
  logic                w_full;
  logic                w_commit;

  // Candidate filter and grid snap (offset from the field origin, then drop
  // the sub-cell bits so the query always lands on a cell origin).
  assign w_in_range = (rnd_x >= c_x_min) && (rnd_x <= c_x_last) &&
                      (rnd_y >= c_y_min) && (rnd_y <= c_y_last);
  assign w_cand_x   = c_x_min + ((rnd_x - c_x_min) & c_align_mask);
  assign w_cand_y   = c_y_min + ((rnd_y - c_y_min) & c_align_mask);

  // Raster scan step: next column, wrapping to the next row, and the last
  // row wrapping back to the top so the scan covers every cell once.
  assign w_col_last = (r_occ_x >= c_x_last);
  assign w_row_last = (r_occ_y >= c_y_last);
  assign w_next_x   = w_col_last ? c_x_min : (r_occ_x + c_g);
  assign w_next_y   = w_col_last ? (w_row_last ? c_y_min : (r_occ_y + c_g)) : r_occ_y;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_try_inc   = 1'b0;
    w_scan_clr  = 1'b0;
    w_scan_step = 1'b0;
    w_full      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_start     = 1'b1;
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (w_in_range) begin
          w_load      = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!occ_hit) begin
          w_state_nxt = S_COMMIT;
        end else if (r_tries == c_try_last) begin
          w_scan_clr  = 1'b1;
          w_state_nxt = S_SCAN;
        end else begin
          w_try_inc   = 1'b1;
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SCAN: begin
        if (!occ_hit) begin
          w_state_nxt = S_COMMIT;
        end else if (r_scan_cnt == c_scan_last) begin
          w_full      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_scan_step = 1'b1;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_occ_x      <= '0;
      r_occ_y      <= '0;
      r_food_x     <= '0;
      r_food_y     <= '0;
      r_food_valid <= 1'b0;
      r_done       <= 1'b0;
      r_board_full <= 1'b0;
      r_tries      <= '0;
      r_scan_cnt   <= '0;
    end else begin
      r_done <= w_commit;
      if (w_start) begin
        r_food_valid <= 1'b0;
        r_board_full <= 1'b0;
        r_tries      <= '0;
      end
      if (w_load) begin
        r_occ_x <= w_cand_x;
        r_occ_y <= w_cand_y;
      end
      if (w_try_inc) begin
        r_tries <= r_tries + TRY_W'(1);
      end
      if (w_scan_clr) begin
        r_scan_cnt <= '0;
      end
      if (w_scan_step) begin
        r_occ_x    <= w_next_x;
        r_occ_y    <= w_next_y;
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
      if (w_full) begin
        r_board_full <= 1'b1;
      end
      if (w_commit) begin
        r_food_x     <= r_occ_x;
        r_food_y     <= r_occ_y;
        r_food_valid <= 1'b1;
      end
    end
  end

  assign occ_x      = r_occ_x;
  assign occ_y      = r_occ_y;
  assign xFood      = r_food_x;
  assign yFood      = r_food_y;
  assign food_valid = r_food_valid;
  assign done       = r_done;
  assign board_full = r_board_full;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/food_placement_ctrl.md
# food_placement_ctrl

Sequencer for snake food placement. It takes free-running pseudo-random coordinates from the LFSR and keeps only those inside the playfield. Each accepted candidate is snapped to the snake cell grid and checked against the snake-body occupancy map. The block retries on collision, falls back to a deterministic grid scan after a bounded number of failed tries, and reports the committed food position (or a full board) to the game logic.

## Interface
Parameters:
- X_MIN, 144, first active pixel column (H_SYNC_CYC + H_SYNC_BACK)
- X_MAX, 783, last active pixel column
- Y_MIN, 35, first active line (V_SYNC_CYC + V_SYNC_BACK)
- Y_MAX, 514, last active line
- GRID_LOG2, 4, log2 of the cell size in pixels (16)
- MAX_TRIES, 32, random occupancy hits tolerated before fallback scan

Ports:
- clk1  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- req  in  1  place-food request (pulse or level, sampled only in IDLE)
- rnd_x  in  10  LFSR X coordinate, new value every cycle
- rnd_y  in  10  LFSR Y coordinate, new value every cycle
- occ_x  out  10  registered occupancy query X (cell-aligned)
- occ_y  out  10  registered occupancy query Y (cell-aligned)
- occ_hit  in  1  1 = queried cell holds snake body; valid for the current occ_x/occ_y
- xFood  out  10  committed food X (cell-aligned)
- yFood  out  10  committed food Y (cell-aligned)
- food_valid  out  1  xFood/yFood hold a placed food
- busy  out  1  placement in progress
- done  out  1  one-cycle pulse: food committed
- board_full  out  1  sticky: no free cell found; cleared by next accepted req

## Operation
- Constants: G = 2^GRID_LOG2. NX = (X_MAX-X_MIN+1)>>GRID_LOG2 = 40. NY = 30. NCELLS = NX*NY = 1200. The scan counter is 11 bits.
- Range test: rnd_x in [X_MIN, X_MAX-G+1] and rnd_y in [Y_MIN, Y_MAX-G+1]. Out-of-range samples are discarded and do not count as tries.
- Alignment: cand_x = X_MIN + ((rnd_x - X_MIN) with the low GRID_LOG2 bits cleared). cand_y is formed the same way. All arithmetic is 10-bit unsigned.
- States:
  - IDLE: busy = 0. If req = 1, go to SAMPLE, clear food_valid, board_full and the try counter.
  - SAMPLE: if the sample is in range, load occ_x/occ_y with the candidate and go to CHECK. Otherwise stay in SAMPLE.
  - CHECK: sample occ_hit.
    - occ_hit = 0: go to COMMIT.
    - occ_hit = 1 and tries < MAX_TRIES-1: tries+1, go to SAMPLE.
    - occ_hit = 1 and tries = MAX_TRIES-1: go to SCAN, clear the scan counter.
  - SCAN: sample occ_hit for the current occ_x/occ_y.
    - occ_hit = 0: go to COMMIT.
    - occ_hit = 1: advance occ_x by G. Past the last column, occ_x wraps to X_MIN and occ_y advances by G. Past the last row, occ_y wraps to Y_MIN. Increment the scan counter.
    - Scan counter reaches NCELLS-1 with a hit: set board_full, go to IDLE with food_valid = 0.
  - COMMIT: xFood/yFood <= occ_x/occ_y, food_valid = 1, done = 1 for this cycle only, go to IDLE.
- A req seen while busy is ignored; it is not queued.
- occ_hit is sampled only in CHECK and SCAN.

## Timing
- Reset (asynchronous): state IDLE. xFood, yFood, occ_x, occ_y and all counters are 0. food_valid, busy, done and board_full are 0.
- The responder must present occ_hit for the current occ_x/occ_y within the same cycle. Zero-wait lookup, combinational or half-cycle RAM.
- Best case: req sampled at edge 0 → SAMPLE (busy = 1). Edge 1 → CHECK. Edge 2 → COMMIT. After edge 3, food_valid = 1, done = 1 for one cycle, busy = 0.
- Each random collision costs 2 cycles plus out-of-range wait cycles. Each scan step costs 1 cycle.
- Worst case after fallback is NCELLS scan cycles plus the random phase.
- xFood/yFood are stable while food_valid = 1 and change only in COMMIT.
- Reset asserted mid-placement aborts the operation immediately, with outputs as listed under reset.

## Test plan
- Empty board, rnd = (300,200), req pulse → occ query (288,195); done and food_valid = 1 with xFood = 288, yFood = 195, 3 cycles after req.
- rnd = (50,10) for 5 cycles, then (400,100) → no query during the out-of-range cycles; commit (400,99); try counter unchanged.
- occ_hit forced 1 for the first 3 candidates → exactly 3 retries, commit of the 4th candidate; busy high throughout.
- All random candidates hit; the single free cell is (144,35) → after 32 hits SCAN starts and wraps through the grid; commit (144,35).
- All cells occupied → board_full = 1 after 1200 scan cycles; food_valid = 0; the next req clears board_full.
- req held high during placement, and rst asserted in SCAN → req ignored while busy; after reset, all outputs are 0 and the state is IDLE.
